// File: rtl/gp9001_host_if.sv
// GP9001 host-side op responder: executes level-held CPU op requests against the
// register file and the VRAM port, then handshakes with ACK until the request drops.
module gp9001_host_if #(
  parameter int VRAM_AW    = 14,
  parameter int RD_LAT     = 1,
  parameter int NREGS_LOG2 = 4
) (
  input  logic                  CLK96,
  input  logic                  RESET96n,
  input  logic                  OP_SELECT_REG,
  input  logic                  OP_WRITE_REG,
  input  logic                  OP_WRITE_RAM,
  input  logic                  OP_READ_RAM_H,
  input  logic                  OP_READ_RAM_L,
  input  logic                  OP_SET_RAM_PTR,
  input  logic [15:0]           DIN,
  output logic                  ACK,
  output logic [15:0]           DOUT,
  output logic                  VRAM_REQ,
  input  logic                  VRAM_GNT,
  output logic                  VRAM_WE,
  output logic [VRAM_AW-1:0]    VRAM_ADDR,
  output logic [15:0]           VRAM_D,
  input  logic [15:0]           VRAM_Q,
  input  logic [NREGS_LOG2-1:0] REG_RADDR,
  output logic [15:0]           REG_RDATA
);

  localparam int         NREGS    = 1 << NREGS_LOG2;
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RAMREQ, S_RDWAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [VRAM_AW-1:0]      ptr_q, ptr_d;
  logic [NREGS_LOG2-1:0]   idx_q, idx_d;
  logic                    ack_q, ack_d;
  logic [15:0]             dout_q, dout_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [VRAM_AW-1:0]      addr_q, addr_d;
  logic [15:0]             wd_q, wd_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    reg_we;
  logic [15:0]             regs_q [NREGS];
  logic [15:0]             rdata_q;

  logic any_req, reg_op, ram_op, grant, capture;

  assign reg_op  = OP_SET_RAM_PTR | OP_SELECT_REG | OP_WRITE_REG;
  assign ram_op  = OP_WRITE_RAM | OP_READ_RAM_H | OP_READ_RAM_L;
  assign any_req = reg_op | ram_op;
  // A grant only counts while our request is actually on the bus.
  assign grant   = req_q & VRAM_GNT;
  assign capture = (state_q == S_RDWAIT) && (cnt_q == LAT_LAST);

  always_ff @(posedge CLK96 or negedge RESET96n) begin
    if (!RESET96n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (reg_op)      state_d = S_DONE;
        else if (ram_op) state_d = S_RAMREQ;
      end
      S_RAMREQ: if (grant) state_d = we_q ? S_DONE : S_RDWAIT;
      S_RDWAIT: if (capture) state_d = S_DONE;
      S_DONE:   if (ack_q && !any_req) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    idx_d  = idx_q;
    ack_d  = ack_q;
    dout_d = dout_q;
    req_d  = req_q;
    we_d   = we_q;
    addr_d = addr_q;
    wd_d   = wd_q;
    cnt_d  = cnt_q;
    reg_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (OP_SET_RAM_PTR)     ptr_d = DIN[VRAM_AW-1:0];
        else if (OP_SELECT_REG) idx_d = DIN[NREGS_LOG2-1:0];
        else if (OP_WRITE_REG)  reg_we = 1'b1;
        else if (OP_WRITE_RAM) begin
          req_d  = 1'b1;
          we_d   = 1'b1;
          addr_d = ptr_q;
          wd_d   = DIN;
        end else if (OP_READ_RAM_H || OP_READ_RAM_L) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = ptr_q;
        end
      end
      S_RAMREQ: begin
        if (grant) begin
          req_d = 1'b0;
          cnt_d = 2'd0;
          if (we_q) ptr_d = ptr_q + VRAM_AW'(1);
        end
      end
      S_RDWAIT: begin
        if (capture) begin
          dout_d = VRAM_Q;
          ptr_d  = ptr_q + VRAM_AW'(1);
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_DONE: ack_d = !(ack_q && !any_req);
      default: ;
    endcase
  end

  always_ff @(posedge CLK96 or negedge RESET96n) begin
    if (!RESET96n) begin
      ptr_q  <= '0;
      idx_q  <= '0;
      ack_q  <= 1'b0;
      dout_q <= '0;
      req_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      idx_q  <= idx_d;
      ack_q  <= ack_d;
      dout_q <= dout_d;
      req_q  <= req_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      wd_q   <= wd_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read port samples the array before this edge's write, so same-cycle hits see old data.
  always_ff @(posedge CLK96 or negedge RESET96n) begin
    if (!RESET96n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (reg_we) regs_q[idx_q] <= DIN;
      rdata_q <= regs_q[REG_RADDR];
    end
  end

  assign ACK       = ack_q;
  assign DOUT      = dout_q;
  assign VRAM_REQ  = req_q;
  assign VRAM_WE   = we_q;
  assign VRAM_ADDR = addr_q;
  assign VRAM_D    = wd_q;
  assign REG_RDATA = rdata_q;

endmodule
